// File: rtl/tl_pkg.sv
// Shared definitions for the multi-approach traffic-light controller.
// The state encoding is also driven out on the debug phase port, so the
// values below are fixed and must not be reordered.
package tl_pkg;

  typedef enum logic [1:0] {
    ST_ALLRED = 2'b00,
    ST_YELLOW = 2'b01,
    ST_GREEN  = 2'b10,
    ST_FLASH  = 2'b11
  } tl_state_e;

endpackage

// File: rtl/tl_rr_arbiter.sv
// Combinational round-robin picker. The search starts at the approach after
// i_last and wraps, so i_last itself is the final candidate. When nothing is
// requested, o_next simply echoes i_last.
module tl_rr_arbiter #(
  parameter  int N_WAY = 4,
  localparam int IDX_W = $clog2(N_WAY)
) (
  input  logic [N_WAY-1:0] i_req,
  input  logic [IDX_W-1:0] i_last,
  output logic             o_valid,
  output logic [IDX_W-1:0] o_next
);

  logic [IDX_W-1:0] w_idx;

  // Walk candidates from farthest to nearest so the nearest requester is the last one written.
  always_comb begin
    o_valid = 1'b0;
    o_next  = i_last;
    w_idx   = '0;
    for (int k = N_WAY; k >= 1; k--) begin
      w_idx = IDX_W'((int'(i_last) + k) % N_WAY);
      if (i_req[w_idx]) begin
        o_valid = 1'b1;
        o_next  = w_idx;
      end
    end
  end

endmodule

// File: rtl/tl_multiway_fsm.sv
// N-approach traffic-light controller. Vehicle requests are latched per
// approach and served one green at a time in round-robin order. Every green
// is bracketed by a full yellow and an all-red clearance, and a night mode
// flashes all yellows. Lamps decode only registered state, so asserting reset
// drops every approach to red immediately.
module tl_multiway_fsm
  import tl_pkg::*;
#(
  parameter  int N_WAY     = 4,
  parameter  int CNT_W     = 8,
  parameter  int GREEN_MIN = 4,
  parameter  int GREEN_MAX = 16,
  parameter  int YELLOW_T  = 3,
  parameter  int ALLRED_T  = 2,
  parameter  int FLASH_T   = 2,
  localparam int IDX_W     = $clog2(N_WAY)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_WAY-1:0] sensor,
  input  logic             flash_en,
  output logic [N_WAY-1:0] r_light,
  output logic [N_WAY-1:0] y_light,
  output logic [N_WAY-1:0] g_light,
  output logic [IDX_W-1:0] cur_way,
  output logic [1:0]       phase
);

  // Terminal timer values: the timer counts 0..T-1 inside a phase.
  localparam logic [CNT_W-1:0] C_ALLRED_END = CNT_W'(ALLRED_T - 1);
  localparam logic [CNT_W-1:0] C_GMIN_END   = CNT_W'(GREEN_MIN - 1);
  localparam logic [CNT_W-1:0] C_GMAX_END   = CNT_W'(GREEN_MAX - 1);
  localparam logic [CNT_W-1:0] C_YELLOW_END = CNT_W'(YELLOW_T - 1);
  localparam logic [CNT_W-1:0] C_FLASH_END  = CNT_W'(FLASH_T - 1);

  tl_state_e        r_state;
  logic [CNT_W-1:0] r_timer;
  logic [N_WAY-1:0] r_req;
  logic [IDX_W-1:0] r_cur_way;
  logic             r_flash_ph;

  tl_state_e        w_state_nxt;
  logic [CNT_W-1:0] w_timer_nxt;
  logic [CNT_W-1:0] w_timer_end;
  logic [N_WAY-1:0] w_req_nxt;
  logic [IDX_W-1:0] w_cur_nxt;
  logic             w_ph_nxt;
  logic             w_grant;

  logic [N_WAY-1:0] w_cur_oh;
  logic [N_WAY-1:0] w_green_mask;
  logic [N_WAY-1:0] w_grant_oh;
  logic             w_other_req;
  logic             w_arb_valid;
  logic [IDX_W-1:0] w_arb_next;

  assign w_cur_oh     = N_WAY'(1) << r_cur_way;
  assign w_green_mask = (r_state == ST_GREEN) ? w_cur_oh : '0;
  assign w_grant_oh   = N_WAY'(1) << w_arb_next;
  assign w_other_req  = |(r_req & ~w_cur_oh);

  // The arbiter sees only the registered requests, so a sensor edge costs one cycle before it can win.
  tl_rr_arbiter #(
    .N_WAY (N_WAY)
  ) u_arb (
    .i_req   (r_req),
    .i_last  (r_cur_way),
    .o_valid (w_arb_valid),
    .o_next  (w_arb_next)
  );

  // State register and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_ALLRED;
      r_timer    <= '0;
      r_req      <= '0;
      r_cur_way  <= IDX_W'(N_WAY - 1);
      r_flash_ph <= 1'b1;
    end else begin
      r_state    <= w_state_nxt;
      r_timer    <= w_timer_nxt;
      r_req      <= w_req_nxt;
      r_cur_way  <= w_cur_nxt;
      r_flash_ph <= w_ph_nxt;
    end
  end

  // Next-state, phase timer, request latch and flash phase.
  always_comb begin
    w_state_nxt = r_state;
    w_cur_nxt   = r_cur_way;
    w_ph_nxt    = r_flash_ph;
    w_grant     = 1'b0;
    w_timer_end = C_ALLRED_END;
    w_timer_nxt = r_timer;

    case (r_state)
      ST_ALLRED: begin
        w_timer_end = C_ALLRED_END;
        if (r_timer == C_ALLRED_END) begin
          // Night mode outranks any waiting traffic.
          if (flash_en) begin
            w_state_nxt = ST_FLASH;
          end else if (w_arb_valid) begin
            w_state_nxt = ST_GREEN;
            w_cur_nxt   = w_arb_next;
            w_grant     = 1'b1;
          end
        end
      end
      ST_GREEN: begin
        w_timer_end = C_GMAX_END;
        if ((r_timer == C_GMAX_END) ||
            ((r_timer >= C_GMIN_END) && w_other_req) ||
            flash_en) begin
          w_state_nxt = ST_YELLOW;
        end
      end
      ST_YELLOW: begin
        w_timer_end = C_YELLOW_END;
        if (r_timer == C_YELLOW_END) begin
          w_state_nxt = ST_ALLRED;
        end
      end
      ST_FLASH: begin
        w_timer_end = C_FLASH_END;
        if (!flash_en) begin
          w_state_nxt = ST_ALLRED;
          w_ph_nxt    = 1'b1;
        end else if (r_timer == C_FLASH_END) begin
          w_ph_nxt = ~r_flash_ph;
        end
      end
      default: begin
        w_state_nxt = ST_ALLRED;
      end
    endcase

    // Timer restarts on every state change and on each flash half-period, else saturates.
    if (w_state_nxt != r_state) begin
      w_timer_nxt = '0;
    end else if ((r_state == ST_FLASH) && (r_timer == C_FLASH_END)) begin
      w_timer_nxt = '0;
    end else if (r_timer != w_timer_end) begin
      w_timer_nxt = r_timer + 1'b1;
    end

    // The approach being served ignores its own sensor; the granted bit clears even if its sensor is high.
    w_req_nxt = (r_req | (sensor & ~w_green_mask)) & ~(w_grant ? w_grant_oh : '0);
  end

  // Moore lamp decode from registered state only.
  always_comb begin
    r_light = '1;
    y_light = '0;
    g_light = '0;
    case (r_state)
      ST_GREEN: begin
        g_light = w_cur_oh;
        r_light = ~w_cur_oh;
      end
      ST_YELLOW: begin
        y_light = w_cur_oh;
        r_light = ~w_cur_oh;
      end
      ST_FLASH: begin
        r_light = '0;
        y_light = {N_WAY{r_flash_ph}};
      end
      default: begin
        r_light = '1;
      end
    endcase
  end

  assign cur_way = r_cur_way;
  assign phase   = r_state;

endmodule

// File: tb/tb_tl_multiway_fsm.sv
// Bench for tl_multiway_fsm: directed scenarios plus a randomized run, each
// compared against a phase-age reference model of the controller.
module tb_tl_multiway_fsm;

  localparam int N    = 4;
  localparam int GMIN = 4;
  localparam int GMAX = 16;
  localparam int YT   = 3;
  localparam int ART  = 2;
  localparam int FT   = 2;

  localparam logic [1:0] MR = 2'd0;
  localparam logic [1:0] MY = 2'd1;
  localparam logic [1:0] MG = 2'd2;
  localparam logic [1:0] MF = 2'd3;

  typedef struct packed {
    logic [1:0] mode;
    int         age;
    logic [3:0] req;
    logic [1:0] cur;
  } m_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] sensor;
  logic       flash_en;
  logic [3:0] r_light, y_light, g_light;
  logic [1:0] cur_way;
  logic [1:0] phase;
  logic [15:0] dut_snap;

  int n_checks = 0;
  int n_fail   = 0;
  m_t m;

  tl_multiway_fsm #(
    .N_WAY(N), .CNT_W(8), .GREEN_MIN(GMIN), .GREEN_MAX(GMAX),
    .YELLOW_T(YT), .ALLRED_T(ART), .FLASH_T(FT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .sensor(sensor), .flash_en(flash_en),
    .r_light(r_light), .y_light(y_light), .g_light(g_light),
    .cur_way(cur_way), .phase(phase)
  );

  always #5 clk = ~clk;

  assign dut_snap = {r_light, y_light, g_light, cur_way, phase};

  function automatic m_t model_reset();
    m_t s;
    s.mode = MR; s.age = 0; s.req = 4'b0; s.cur = 2'(N - 1);
    return s;
  endfunction

  // One clock of the controller described as "cycles spent in the current phase".
  function automatic m_t model_next(m_t s, logic [3:0] sens, logic fl);
    m_t n;
    logic [3:0] own;
    int pick;
    n = s;
    n.age = s.age + 1;
    own = 4'b0001 << s.cur;
    if (s.mode == MG) n.req = s.req | (sens & ~own);
    else n.req = s.req | sens;
    case (s.mode)
      MR: if (s.age >= ART - 1) begin
        if (fl) n.mode = MF;
        else if (s.req != 4'b0) begin
          pick = -1;
          for (int k = 1; k <= N; k++)
            if (pick < 0 && s.req[(int'(s.cur) + k) % N]) pick = (int'(s.cur) + k) % N;
          n.mode = MG;
          n.cur = 2'(pick);
          n.req[pick] = 1'b0;
        end
      end
      MG: if (s.age == GMAX - 1 || (s.age >= GMIN - 1 && (s.req & ~own) != 4'b0) || fl) n.mode = MY;
      MY: if (s.age == YT - 1) n.mode = MR;
      default: if (!fl) n.mode = MR;
    endcase
    if (n.mode != s.mode) n.age = 0;
    return n;
  endfunction

  function automatic logic [15:0] model_snap(m_t s);
    logic [3:0] oh, r, y, g;
    oh = 4'b0001 << s.cur;
    r = 4'hF; y = 4'h0; g = 4'h0;
    case (s.mode)
      MG: begin g = oh; r = ~oh; end
      MY: begin y = oh; r = ~oh; end
      MF: begin r = 4'h0; y = (((s.age / FT) % 2) == 0) ? 4'hF : 4'h0; end
      default: r = 4'hF;
    endcase
    return {r, y, g, s.cur, s.mode};
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m <= model_reset();
    else m <= model_next(m, sensor, flash_en);
  end

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; sensor = 4'b0; flash_en = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0; sensor = 4'b0; flash_en = 1'b0;
    @(negedge clk);
    n_checks++;
    if (r_light !== 4'hF || y_light !== 4'h0 || g_light !== 4'h0 || phase !== 2'b00 || cur_way !== 2'd3) begin
      n_fail++;
      $display("FAIL reset_state: r=%b y=%b g=%b cur=%0d phase=%b, want r=1111 y=0000 g=0000 cur=3 phase=00",
               r_light, y_light, g_light, cur_way, phase);
    end
    rst_n = 1'b1;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      n_checks++;
      if (r_light !== 4'hF || phase !== 2'b00) begin
        n_fail++;
        $display("FAIL idle_red cycle %0d: r=%b phase=%b, want r=1111 phase=00", c, r_light, phase);
      end
      n_checks++;
      if (dut_snap !== model_snap(m)) begin
        n_fail++;
        $display("FAIL idle_model cycle %0d: got %b want %b", c, dut_snap, model_snap(m));
      end
    end
  endtask

  task automatic test_single_request();
    int ng, ny, bad;
    do_reset();
    @(negedge clk); sensor = 4'b0100;
    @(negedge clk); sensor = 4'b0000;
    ng = 0; ny = 0; bad = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      n_checks++;
      if (dut_snap !== model_snap(m)) begin
        n_fail++;
        $display("FAIL single_model cycle %0d: got %b want %b", c, dut_snap, model_snap(m));
      end
      if (g_light === 4'b0100) ng++;
      else if (y_light === 4'b0100) ny++;
      else if (!(r_light === 4'hF && y_light === 4'h0 && g_light === 4'h0)) bad++;
    end
    n_checks++;
    if (ng != GMAX || ny != YT || bad != 0) begin
      n_fail++;
      $display("FAIL single_timing: green=%0d yellow=%0d other=%0d, want green=16 yellow=3 other=0", ng, ny, bad);
    end
    n_checks++;
    if (cur_way !== 2'd2 || phase !== 2'b00) begin
      n_fail++;
      $display("FAIL single_final: cur=%0d phase=%b, want cur=2 phase=00", cur_way, phase);
    end
  endtask

  task automatic test_min_green();
    bit found;
    int t_y, t_g;
    do_reset();
    @(negedge clk); sensor = 4'b0001;
    @(negedge clk); sensor = 4'b0000;
    found = 1'b0;
    for (int c = 0; c < 10 && !found; c++) begin
      @(negedge clk);
      if (g_light === 4'b0001) found = 1'b1;
    end
    n_checks++;
    if (!found) begin
      n_fail++;
      $display("FAIL min_green_start: g=%b, want 0001 within 10 cycles", g_light);
    end
    sensor = 4'b0010;
    t_y = -1; t_g = -1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      n_checks++;
      if (dut_snap !== model_snap(m)) begin
        n_fail++;
        $display("FAIL min_green_model cycle %0d: got %b want %b", c, dut_snap, model_snap(m));
      end
      if (t_y < 0 && y_light !== 4'b0) t_y = c;
      if (t_g < 0 && g_light === 4'b0010) t_g = c;
    end
    sensor = 4'b0000;
    n_checks++;
    if (t_y != GMIN || t_g != GMIN + YT + ART) begin
      n_fail++;
      $display("FAIL min_green_preempt: yellow at %0d green1 at %0d, want 4 and 9", t_y, t_g);
    end
  endtask

  task automatic test_all_requests();
    int order[$];
    int lens[$];
    int exp_order[5] = '{0, 1, 2, 3, 0};
    int run;
    logic [3:0] prev;
    int idx;
    do_reset();
    sensor = 4'hF;
    run = 0; prev = 4'b0;
    for (int c = 0; c < 45; c++) begin
      @(negedge clk);
      n_checks++;
      if (dut_snap !== model_snap(m)) begin
        n_fail++;
        $display("FAIL all_model cycle %0d: got %b want %b", c, dut_snap, model_snap(m));
      end
      n_checks++;
      if ($countones(g_light) > 1 || $countones(y_light) > 1) begin
        n_fail++;
        $display("FAIL all_exclusive cycle %0d: g=%b y=%b, want at most one bit each", c, g_light, y_light);
      end
      if (g_light !== 4'b0) begin
        if (g_light !== prev) begin
          if (run > 0) lens.push_back(run);
          idx = 0;
          for (int i = 0; i < N; i++) if (g_light[i]) idx = i;
          order.push_back(idx);
          run = 1;
        end else run++;
      end else if (run > 0) begin
        lens.push_back(run);
        run = 0;
      end
      prev = g_light;
    end
    sensor = 4'b0;
    n_checks++;
    if (order.size() != 5 || lens.size() != 5) begin
      n_fail++;
      $display("FAIL all_count: greens=%0d runs=%0d, want 5 and 5", order.size(), lens.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        n_checks++;
        if (order[i] != exp_order[i] || lens[i] != GMIN) begin
          n_fail++;
          $display("FAIL all_order green %0d: way=%0d len=%0d, want way=%0d len=4", i, order[i], lens[i], exp_order[i]);
        end
      end
    end
  endtask

  task automatic test_flash();
    logic [3:0] ye;
    do_reset();
    @(negedge clk); sensor = 4'b0001;
    @(negedge clk); sensor = 4'b0000;
    @(negedge clk);
    n_checks++;
    if (g_light !== 4'b0001) begin
      n_fail++;
      $display("FAIL flash_green0: g=%b, want 0001", g_light);
    end
    @(negedge clk);
    flash_en = 1'b1;
    for (int i = 0; i < YT; i++) begin
      @(negedge clk);
      n_checks++;
      if (y_light !== 4'b0001 || g_light !== 4'b0 || phase !== 2'b01) begin
        n_fail++;
        $display("FAIL flash_yellow %0d: y=%b g=%b phase=%b, want y=0001 g=0000 phase=01", i, y_light, g_light, phase);
      end
    end
    for (int i = 0; i < ART; i++) begin
      @(negedge clk);
      n_checks++;
      if (r_light !== 4'hF || y_light !== 4'b0 || phase !== 2'b00) begin
        n_fail++;
        $display("FAIL flash_allred %0d: r=%b y=%b phase=%b, want r=1111 y=0000 phase=00", i, r_light, y_light, phase);
      end
    end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      ye = (((i / FT) % 2) == 0) ? 4'hF : 4'h0;
      n_checks++;
      if (y_light !== ye || r_light !== 4'b0 || g_light !== 4'b0 || phase !== 2'b11) begin
        n_fail++;
        $display("FAIL flash_blink %0d: r=%b y=%b g=%b phase=%b, want r=0000 y=%b g=0000 phase=11",
                 i, r_light, y_light, g_light, phase, ye);
      end
      n_checks++;
      if (dut_snap !== model_snap(m)) begin
        n_fail++;
        $display("FAIL flash_model %0d: got %b want %b", i, dut_snap, model_snap(m));
      end
      if (i == 4) sensor = 4'b0100;
      if (i == 5) sensor = 4'b0000;
    end
    flash_en = 1'b0;
    for (int i = 0; i < ART; i++) begin
      @(negedge clk);
      n_checks++;
      if (r_light !== 4'hF || y_light !== 4'b0 || phase !== 2'b00) begin
        n_fail++;
        $display("FAIL flash_exit_red %0d: r=%b y=%b phase=%b, want r=1111 y=0000 phase=00", i, r_light, y_light, phase);
      end
    end
    @(negedge clk);
    n_checks++;
    if (g_light !== 4'b0100 || cur_way !== 2'd2) begin
      n_fail++;
      $display("FAIL flash_served: g=%b cur=%0d, want g=0100 cur=2", g_light, cur_way);
    end
  endtask

  task automatic test_async_reset();
    bit found;
    do_reset();
    @(negedge clk); sensor = 4'b0001;
    @(negedge clk); sensor = 4'b0000;
    found = 1'b0;
    for (int c = 0; c < 30 && !found; c++) begin
      @(negedge clk);
      if (y_light !== 4'b0) found = 1'b1;
    end
    n_checks++;
    if (!found) begin
      n_fail++;
      $display("FAIL async_reach_yellow: y=%b, want nonzero within 30 cycles", y_light);
    end
    #2;
    rst_n = 1'b0;
    sensor = 4'b1011;
    #1;
    n_checks++;
    if (r_light !== 4'hF || y_light !== 4'b0 || g_light !== 4'b0 || phase !== 2'b00) begin
      n_fail++;
      $display("FAIL async_reset_lamps: r=%b y=%b g=%b phase=%b, want r=1111 y=0000 g=0000 phase=00",
               r_light, y_light, g_light, phase);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    found = 1'b0;
    for (int c = 0; c < 10 && !found; c++) begin
      @(negedge clk);
      if (g_light !== 4'b0) found = 1'b1;
    end
    n_checks++;
    if (!found || g_light !== 4'b0001 || cur_way !== 2'd0) begin
      n_fail++;
      $display("FAIL async_restart: g=%b cur=%0d, want g=0001 cur=0", g_light, cur_way);
    end
    sensor = 4'b0;
  endtask

  task automatic test_random();
    int red_run;
    logic [3:0] prev_g;
    do_reset();
    red_run = 0;
    prev_g = 4'b0;
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      n_checks++;
      if (dut_snap !== model_snap(m)) begin
        n_fail++;
        $display("FAIL random_model cycle %0d: got %b want %b", c, dut_snap, model_snap(m));
      end
      if (phase !== 2'b11) begin
        n_checks++;
        if ($countones(g_light | y_light) > 1) begin
          n_fail++;
          $display("FAIL random_exclusive cycle %0d: g=%b y=%b, want at most one lit", c, g_light, y_light);
        end
      end
      if (g_light !== 4'b0 && prev_g === 4'b0) begin
        n_checks++;
        if (red_run < ART) begin
          n_fail++;
          $display("FAIL random_clearance cycle %0d: all-red run=%0d, want >= %0d", c, red_run, ART);
        end
      end
      if (r_light === 4'hF) red_run++;
      else red_run = 0;
      prev_g = g_light;
      sensor = 4'($urandom) & 4'($urandom);
      if ($urandom_range(0, 39) == 0) flash_en = ~flash_en;
    end
    sensor = 4'b0;
    flash_en = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    sensor = 4'b0;
    flash_en = 1'b0;
    test_reset();
    test_single_request();
    test_min_green();
    test_all_requests();
    test_flash();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
